avalon_axi_lite_master: RTL and testbench
=========================================

Name: avalon_axi_lite_master

Overview:
- Bridge from an Avalon-MM slave port to an AXI4-Lite master port. It is the initiator-side counterpart of our AXI-Lite slave to Avalon bridge.
- Lets Avalon-mastered logic (PCP/soft CPU side) reach AXI-Lite peripherals.
- One outstanding transaction at a time, 32-bit data. The Avalon side is stalled with waitrequest until the AXI response arrives.
- Reports SLVERR/DECERR through a sticky error flag.

Parameters:
- C_BASEADDR, 32'h0000_0000, AXI address offset added to the Avalon byte address.
- C_AVS_ADDR_WIDTH, 11, Avalon word-address width.
- C_M_AXI_ADDR_WIDTH, 32, AXI address width.
- C_M_AXI_DATA_WIDTH, 32, data width. Only 32 is supported.

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  reset
- avs_address  in  C_AVS_ADDR_WIDTH  Avalon word address
- avs_read  in  1  read request
- avs_write  in  1  write request
- avs_byteenable  in  4  byte lanes
- avs_writedata  in  32  write data
- avs_readdata  out  32  read data; valid when avs_read=1 and avs_waitrequest=0
- avs_waitrequest  out  1  stall
- err_sticky  out  1  set on a non-OKAY BRESP/RRESP
- err_clear  in  1  clears err_sticky
- M_AXI_AWADDR  out  C_M_AXI_ADDR_WIDTH
- M_AXI_AWPROT  out  3  constant 3'b000
- M_AXI_AWVALID  out  1
- M_AXI_AWREADY  in  1
- M_AXI_WDATA  out  32
- M_AXI_WSTRB  out  4
- M_AXI_WVALID  out  1
- M_AXI_WREADY  in  1
- M_AXI_BRESP  in  2
- M_AXI_BVALID  in  1
- M_AXI_BREADY  out  1
- M_AXI_ARADDR  out  C_M_AXI_ADDR_WIDTH
- M_AXI_ARPROT  out  3  constant 3'b000
- M_AXI_ARVALID  out  1
- M_AXI_ARREADY  in  1
- M_AXI_RDATA  in  32
- M_AXI_RRESP  in  2
- M_AXI_RVALID  in  1
- M_AXI_RREADY  out  1

Behaviour:
- Reset: ARESETN, synchronous, active-low; clock ACLK.
- Reset values:
  - avs_waitrequest=1, avs_readdata=0, err_sticky=0.
  - All AXI VALID/READY outputs 0.
  - Address/data registers 0.
  - State IDLE.
- Reset mid-transaction: the FSM returns to IDLE on that edge and the AXI valids drop. Interconnect reset is system-level and simultaneous.
- All outputs are registered. No combinational path from an input to an output.
- Address: AxADDR = C_BASEADDR + {avs_address, 2'b00}, truncated to C_M_AXI_ADDR_WIDTH.
- WSTRB = avs_byteenable. Read requests ignore byteenable and read the full word.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
- IDLE (waitrequest=1):
  - avs_write=1: capture addr/data/strb, assert AWVALID=1 and WVALID=1 next cycle, go to WR_REQ.
  - Else avs_read=1: capture addr, assert ARVALID=1, go to RD_REQ.
  - Simultaneous read and write (illegal Avalon): write wins.
- WR_REQ:
  - Track aw_done and w_done independently.
  - AWVALID drops the cycle after the AWREADY handshake; WVALID drops the cycle after the WREADY handshake. Either may come first or both together.
  - Once both are done: BREADY=1, go to WR_RESP.
- WR_RESP:
  - On BVALID&BREADY: BREADY=0.
  - If BRESP!=00, set err_sticky.
  - Go to DONE.
- RD_REQ: on ARREADY: ARVALID=0, RREADY=1, go to RD_RESP.
- RD_RESP:
  - On RVALID: latch RDATA into avs_readdata, RREADY=0.
  - If RRESP!=00, set err_sticky.
  - Go to DONE.
- DONE:
  - avs_waitrequest=0 for exactly one cycle.
  - Next state IDLE. A new command is sampled in IDLE, not in DONE.
- Latency with zero-wait AXI slave: command seen at cycle 0; AxVALID high at cycle 1; xREADY high at cycle 2; waitrequest low at cycle 3. A single-cycle accept gives 4 cycles per transaction.
- AXI rules:
  - VALID, once high, stays high with stable payload until its handshake.
  - No dependency on READY before asserting VALID.
- err_sticky:
  - A set in the same cycle as err_clear wins.
  - err_clear in any other cycle clears it.
- No timeout. A hung slave stalls Avalon indefinitely.

Decomposition:
- Shared package (axi_lite_pkg):
  - Response codes OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - FSM state encoding.
  - AXPROT default.
- Single module. No sub-module is needed.

Test Plan:
- Write addr=0x010, data=0xA5A5_1234, be=0xF, slave ready in the first cycle with BRESP=00 -> AWADDR=0x40, WSTRB=0xF, one AW handshake and one W handshake, waitrequest low at cycle 3, err_sticky=0.
- Read addr=0x3, AWREADY held low, ARREADY after 5 cycles, RDATA=0xDEAD_BEEF two cycles later -> ARVALID stable and high for 6 cycles, avs_readdata=0xDEADBEEF when waitrequest=0, waitrequest low for exactly 1 cycle.
- Write with WREADY at cycle 1 and AWREADY at cycle 4 -> WVALID drops at cycle 2, AWVALID held until cycle 4, BREADY only after both handshakes, single completion.
- Read with RRESP=2'b10 -> err_sticky=1 after completion. Next write with OKAY keeps it 1. err_clear pulse -> 0.
- avs_read and avs_write both 1 -> only the AW/W channels fire and ARVALID stays 0.
- ARESETN low while in WR_RESP -> next cycle all valids/readys 0, waitrequest=1, state IDLE; a subsequent read completes normally.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// ----------------------------------------------------------------------------
// axi_lite_pkg
//   Shared AXI4-Lite definitions for the Avalon-to-AXI-Lite master bridge:
//   response codes, the bridge FSM state encoding, the default AxPROT value
//   and a helper that classifies a response as an error.
//   No ports (package).
// ----------------------------------------------------------------------------
package axi_lite_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_RD_REQ,
        ST_RD_RESP,
        ST_DONE
    } state_e;

    // Unprivileged, secure, data access.
    localparam logic [2:0] AXPROT_DEFAULT = 3'b000;

    // Anything other than OKAY is reported through the sticky error flag.
    function automatic logic resp_is_error(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/avalon_axi_lite_master.sv
// ----------------------------------------------------------------------------
// avalon_axi_lite_master
//   Avalon-MM slave port -> AXI4-Lite master port bridge. One outstanding
//   transaction; the Avalon master is held off with avs_waitrequest until the
//   AXI response has arrived, then waitrequest drops for exactly one cycle.
//   Non-OKAY BRESP/RRESP sets a sticky error flag.
//
// Ports
//   ACLK, ARESETN     clock, synchronous active-low reset
//   avs_*             Avalon-MM slave (word address, read/write, byteenable)
//   err_sticky/clear  sticky error flag and its clear strobe
//   M_AXI_*           AXI4-Lite master (AW, W, B, AR, R channels)
//
// Every output comes straight from a register; no input reaches an output
// combinationally.
// ----------------------------------------------------------------------------
module avalon_axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR         = 32'h0000_0000,
    parameter int          C_AVS_ADDR_WIDTH   = 11,
    parameter int          C_M_AXI_ADDR_WIDTH = 32,
    parameter int          C_M_AXI_DATA_WIDTH = 32
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,

    input  logic [C_AVS_ADDR_WIDTH-1:0]     avs_address,
    input  logic                            avs_read,
    input  logic                            avs_write,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] avs_byteenable,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   avs_writedata,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   avs_readdata,
    output logic                            avs_waitrequest,

    output logic                            err_sticky,
    input  logic                            err_clear,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;

    state_e          state_q;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q;
    logic [DW/8-1:0] wstrb_q;
    logic [DW-1:0]   rdata_q;
    logic            awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic            wait_q;
    logic            aw_done_q, aw_done_d;
    logic            w_done_q, w_done_d;
    logic            err_q, err_d;
    logic            aw_hs, w_hs, err_set;

    // NOTE: every variable assigned here gets a value first, so no path
    // leaves it holding its old value and no latch is inferred.
    always_comb begin
        aw_hs     = awvalid_q & M_AXI_AWREADY;
        w_hs      = wvalid_q & M_AXI_WREADY;
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;

        err_set = 1'b0;
        if (state_q == ST_WR_RESP && bready_q && M_AXI_BVALID) begin
            err_set = resp_is_error(M_AXI_BRESP);
        end else if (state_q == ST_RD_RESP && rready_q && M_AXI_RVALID) begin
            err_set = resp_is_error(M_AXI_RRESP);
        end
        // A response error in the same cycle as err_clear must not be lost.
        err_d = err_set | (err_q & ~err_clear);

        // Word address to byte address, offset, wrapped to the AXI width.
        addr_d = AW'(C_BASEADDR) + AW'({avs_address, 2'b00});
    end

    // NOTE: non-blocking assignments for all state so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            wait_q    <= 1'b1;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            err_q <= err_d;
            case (state_q)
                ST_IDLE: begin
                    // Write has priority over a (protocol-illegal) concurrent read.
                    if (avs_write) begin
                        addr_q    <= addr_d;
                        wdata_q   <= avs_writedata;
                        wstrb_q   <= avs_byteenable;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        state_q   <= ST_WR_REQ;
                    end else if (avs_read) begin
                        addr_q    <= addr_d;
                        arvalid_q <= 1'b1;
                        state_q   <= ST_RD_REQ;
                    end
                end
                ST_WR_REQ: begin
                    // AW and W complete independently, in either order.
                    if (aw_hs) awvalid_q <= 1'b0;
                    if (w_hs)  wvalid_q  <= 1'b0;
                    aw_done_q <= aw_done_d;
                    w_done_q  <= w_done_d;
                    if (aw_done_d && w_done_d) begin
                        bready_q <= 1'b1;
                        state_q  <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (M_AXI_BVALID) begin
                        bready_q <= 1'b0;
                        wait_q   <= 1'b0;
                        state_q  <= ST_DONE;
                    end
                end
                ST_RD_REQ: begin
                    if (M_AXI_ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= ST_RD_RESP;
                    end
                end
                ST_RD_RESP: begin
                    if (M_AXI_RVALID) begin
                        rdata_q  <= M_AXI_RDATA;
                        rready_q <= 1'b0;
                        wait_q   <= 1'b0;
                        state_q  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // One-cycle Avalon completion; next command is taken in IDLE.
                    wait_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign avs_readdata    = rdata_q;
    assign avs_waitrequest = wait_q;
    assign err_sticky      = err_q;

    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWPROT  = AXPROT_DEFAULT;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARPROT  = AXPROT_DEFAULT;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_avalon_axi_lite_master.sv
// ----------------------------------------------------------------------------
// tb_avalon_axi_lite_master
//   Directed stimulus with a transaction-level expectation (address, data,
//   response, error flag) and a per-cycle monitor that checks AXI channel
//   rules, handshake counts, completion pulse and reset values.
// ----------------------------------------------------------------------------
module tb_avalon_axi_lite_master;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          TMO  = 100;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [10:0] avs_address;
    logic        avs_read, avs_write;
    logic [3:0]  avs_byteenable;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic        err_sticky, err_clear;
    logic [31:0] M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA, M_AXI_RDATA;
    logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
    logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
    logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic        M_AXI_RVALID, M_AXI_RREADY;

    avalon_axi_lite_master #(.C_BASEADDR(BASE)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_byteenable(avs_byteenable), .avs_writedata(avs_writedata),
        .avs_readdata(avs_readdata), .avs_waitrequest(avs_waitrequest),
        .err_sticky(err_sticky), .err_clear(err_clear),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
        .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    always #5 ACLK = ~ACLK;

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- transaction-level expectation ----------------
    int          txn_id = 0;
    bit          txn_active = 0;
    bit          exp_wr = 0;
    logic [31:0] exp_addr = '0, exp_wdata = '0, exp_rdata = '0;
    logic [3:0]  exp_strb = '0;
    bit          exp_err = 0;
    int          start_cyc = 0;

    function automatic logic [31:0] axi_addr(input int unsigned word);
        return BASE + 32'(word) * 32'd4;
    endfunction

    // ---------------- per-transaction statistics (monitor) ----------------
    int          seen_id = 0;
    int          aw_hi, w_hi, ar_hi, aw_hs_n, w_hs_n, b_hs_n, ar_hs_n, r_hs_n, done_n, lat;
    logic [31:0] rec_awaddr, rec_araddr, rec_rdata;
    bit          model_err = 0, clear_prev = 0, rst_prev = 0, prev_wait = 1;
    bit          prev_awv, prev_aw_hs, prev_wv, prev_w_hs, prev_arv, prev_ar_hs;
    bit          prev_b_hs, prev_r_hs;
    logic [31:0] prev_awaddr, prev_araddr, prev_wdata;
    logic [3:0]  prev_wstrb;

    always @(negedge ACLK) begin
        if (!rst_prev) begin
            check("rst_ctrl", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID,
                               M_AXI_RREADY, avs_waitrequest, err_sticky}, 7'b0000010);
            check("rst_readdata", avs_readdata, 32'h0);
            check("rst_addr_data", {M_AXI_AWADDR, M_AXI_WDATA}, 64'h0);
            model_err = 0;
            {prev_awv, prev_aw_hs, prev_wv, prev_w_hs, prev_arv, prev_ar_hs} = '0;
            {prev_b_hs, prev_r_hs} = '0;
            prev_wait = 1;
        end else begin
            if (txn_id != seen_id) begin
                seen_id = txn_id;
                {aw_hi, w_hi, ar_hi, aw_hs_n, w_hs_n, b_hs_n, ar_hs_n, r_hs_n, done_n} = '0;
                rec_awaddr = '0; rec_araddr = '0;
            end
            // Error flag: set by an erroring completion, else cleared by a
            // sampled err_clear.
            if (!avs_waitrequest && exp_err) model_err = 1;
            else if (clear_prev)             model_err = 0;
            check("err_sticky", err_sticky, model_err);
            check("prot", {M_AXI_AWPROT, M_AXI_ARPROT}, 6'b0);

            if (prev_awv && !prev_aw_hs)
                check("aw_hold", {M_AXI_AWVALID, M_AXI_AWADDR}, {1'b1, prev_awaddr});
            if (prev_aw_hs) check("aw_drop", M_AXI_AWVALID, 1'b0);
            if (prev_wv && !prev_w_hs)
                check("w_hold", {M_AXI_WVALID, M_AXI_WSTRB, M_AXI_WDATA}, {1'b1, prev_wstrb, prev_wdata});
            if (prev_w_hs) check("w_drop", M_AXI_WVALID, 1'b0);
            if (prev_arv && !prev_ar_hs)
                check("ar_hold", {M_AXI_ARVALID, M_AXI_ARADDR}, {1'b1, prev_araddr});
            if (prev_ar_hs) check("ar_drop", M_AXI_ARVALID, 1'b0);
            if (prev_b_hs)  check("bready_drop", M_AXI_BREADY, 1'b0);
            if (prev_r_hs)  check("rready_drop", M_AXI_RREADY, 1'b0);

            if (txn_active && exp_wr)  check("no_ar_on_write", M_AXI_ARVALID, 1'b0);
            if (txn_active && !exp_wr) check("no_aw_w_on_read", {M_AXI_AWVALID, M_AXI_WVALID}, 2'b0);

            if (M_AXI_AWVALID) begin
                aw_hi++;
                if (aw_hi == 1) rec_awaddr = M_AXI_AWADDR;
                if (txn_active && exp_wr) check("awaddr", M_AXI_AWADDR, exp_addr);
            end
            if (M_AXI_WVALID) begin
                w_hi++;
                if (txn_active && exp_wr) check("wdata_wstrb", {M_AXI_WSTRB, M_AXI_WDATA}, {exp_strb, exp_wdata});
            end
            if (M_AXI_ARVALID) begin
                ar_hi++;
                if (ar_hi == 1) rec_araddr = M_AXI_ARADDR;
                if (txn_active && !exp_wr) check("araddr", M_AXI_ARADDR, exp_addr);
            end
            if (M_AXI_BREADY)  check("bready_after_aw_w", (aw_hs_n == 1 && w_hs_n == 1), 1'b1);
            if (M_AXI_RREADY)  check("rready_after_ar", ar_hs_n, 64'd1);

            if (!avs_waitrequest) begin
                done_n++;
                lat       = cyc - start_cyc;
                rec_rdata = avs_readdata;
                check("wait_pulse", prev_wait, 1'b1);
                check("done_once", done_n, 64'd1);
                check("done_in_txn", txn_active, 1'b1);
                if (exp_wr)
                    check("wr_handshakes", {aw_hs_n[7:0], w_hs_n[7:0], b_hs_n[7:0]}, 24'h010101);
                else begin
                    check("rd_handshakes", {ar_hs_n[7:0], r_hs_n[7:0]}, 16'h0101);
                    check("readdata", avs_readdata, exp_rdata);
                end
            end

            prev_aw_hs = M_AXI_AWVALID & M_AXI_AWREADY;
            prev_w_hs  = M_AXI_WVALID & M_AXI_WREADY;
            prev_ar_hs = M_AXI_ARVALID & M_AXI_ARREADY;
            prev_b_hs  = M_AXI_BVALID & M_AXI_BREADY;
            prev_r_hs  = M_AXI_RVALID & M_AXI_RREADY;
            if (prev_aw_hs) aw_hs_n++;
            if (prev_w_hs)  w_hs_n++;
            if (prev_ar_hs) ar_hs_n++;
            if (prev_b_hs)  b_hs_n++;
            if (prev_r_hs)  r_hs_n++;
            prev_awv    = M_AXI_AWVALID;
            prev_wv     = M_AXI_WVALID;
            prev_arv    = M_AXI_ARVALID;
            prev_awaddr = M_AXI_AWADDR;
            prev_araddr = M_AXI_ARADDR;
            prev_wdata  = M_AXI_WDATA;
            prev_wstrb  = M_AXI_WSTRB;
            prev_wait   = avs_waitrequest;
        end
        rst_prev   = ARESETN;
        clear_prev = err_clear;
    end

    // ---------------- AXI slave and Avalon master helpers ----------------
    function automatic logic chan_valid(input int ch);
        case (ch)
            0:       return M_AXI_AWVALID;
            1:       return M_AXI_WVALID;
            default: return M_AXI_ARVALID;
        endcase
    endfunction

    task automatic set_ready(input int ch, input logic v);
        case (ch)
            0:       M_AXI_AWREADY = v;
            1:       M_AXI_WREADY  = v;
            default: M_AXI_ARREADY = v;
        endcase
    endtask

    // Raise READY for one cycle after VALID has been high for dly cycles.
    task automatic ready_sink(input int ch, input int dly);
        int n = 0;
        bit ok = 0;
        for (int c = 0; c < TMO; c++) begin
            @(posedge ACLK); #1;
            if (chan_valid(ch)) begin
                if (n == dly) begin
                    set_ready(ch, 1'b1);
                    @(posedge ACLK); #1;
                    set_ready(ch, 1'b0);
                    ok = 1;
                    break;
                end
                n++;
            end
        end
        if (!ok) check($sformatf("ready_timeout_ch%0d", ch), 0, 1);
    endtask

    task automatic b_slave(input int dly, input logic [1:0] resp);
        int n = 0;
        bit ok = 0;
        for (int c = 0; c < TMO; c++) begin
            @(posedge ACLK); #1;
            if (M_AXI_BREADY) begin
                if (n == dly) begin
                    M_AXI_BVALID = 1'b1; M_AXI_BRESP = resp;
                    @(posedge ACLK); #1;
                    M_AXI_BVALID = 1'b0; M_AXI_BRESP = 2'b00;
                    ok = 1;
                    break;
                end
                n++;
            end
        end
        if (!ok) check("b_timeout", 0, 1);
    endtask

    task automatic r_slave(input int dly, input logic [31:0] data, input logic [1:0] resp);
        int n = 0;
        bit ok = 0;
        for (int c = 0; c < TMO; c++) begin
            @(posedge ACLK); #1;
            if (M_AXI_RREADY) begin
                if (n == dly) begin
                    M_AXI_RVALID = 1'b1; M_AXI_RDATA = data; M_AXI_RRESP = resp;
                    @(posedge ACLK); #1;
                    M_AXI_RVALID = 1'b0; M_AXI_RDATA = '0; M_AXI_RRESP = 2'b00;
                    ok = 1;
                    break;
                end
                n++;
            end
        end
        if (!ok) check("r_timeout", 0, 1);
    endtask

    task automatic issue(input bit wr, input bit rd, input int unsigned word,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input logic [31:0] rdata, input bit err);
        exp_wr = wr; exp_addr = axi_addr(word); exp_wdata = wdata; exp_strb = be;
        exp_rdata = rdata; exp_err = err;
        txn_id++; txn_active = 1; start_cyc = cyc;
        avs_address = word[10:0]; avs_write = wr; avs_read = rd;
        avs_writedata = wdata; avs_byteenable = be;
    endtask

    task automatic wait_done();
        bit ok = 0;
        for (int c = 0; c < TMO; c++) begin
            @(posedge ACLK); #1;
            if (!avs_waitrequest) begin
                avs_write = 1'b0; avs_read = 1'b0; err_clear = 1'b0;
                ok = 1;
                break;
            end
        end
        if (!ok) check("waitrequest_timeout", 0, 1);
        @(posedge ACLK); #1;
        txn_active = 0;
    endtask

    task automatic do_write(input int unsigned word, input logic [31:0] data, input logic [3:0] be,
                            input int aw_dly, input int w_dly, input int b_dly,
                            input logic [1:0] resp, input bit rd_too);
        issue(1'b1, rd_too, word, data, be, 32'h0, resp != 2'b00);
        fork
            ready_sink(0, aw_dly);
            ready_sink(1, w_dly);
            b_slave(b_dly, resp);
            wait_done();
        join
    endtask

    task automatic do_read(input int unsigned word, input logic [31:0] data,
                           input int ar_dly, input int r_dly, input logic [1:0] resp);
        issue(1'b0, 1'b1, word, 32'h0, 4'h0, data, resp != 2'b00);
        fork
            ready_sink(2, ar_dly);
            r_slave(r_dly, data, resp);
            wait_done();
        join
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        ARESETN = 1'b0; err_clear = 1'b0;
        avs_address = '0; avs_read = 1'b0; avs_write = 1'b0;
        avs_byteenable = '0; avs_writedata = '0;
        M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_ARREADY = 1'b0;
        M_AXI_BVALID = 1'b0; M_AXI_BRESP = 2'b00;
        M_AXI_RVALID = 1'b0; M_AXI_RDATA = '0; M_AXI_RRESP = 2'b00;
        repeat (3) @(posedge ACLK);
        #1 ARESETN = 1'b1;
        @(posedge ACLK); #1;

        // Zero-wait write: 4-cycle transaction, completion in cycle 3.
        do_write(32'h010, 32'hA5A5_1234, 4'hF, 0, 0, 0, 2'b00, 1'b0);
        check("t1_awaddr", rec_awaddr, 32'h0000_0040);
        check("t1_latency", lat, 3);
        check("t1_aw_cycles", aw_hi, 1);
        check("t1_err", err_sticky, 1'b0);

        // Read with ARREADY after 5 cycles, RVALID one cycle after RREADY.
        do_read(32'h3, 32'hDEAD_BEEF, 5, 1, 2'b00);
        check("t2_araddr", rec_araddr, 32'h0000_000C);
        check("t2_ar_cycles", ar_hi, 6);
        check("t2_readdata", rec_rdata, 32'hDEAD_BEEF);
        check("t2_latency", lat, 9);

        // W accepted at once, AW after 3 extra cycles.
        do_write(32'h022, 32'h0BAD_F00D, 4'b0101, 3, 0, 0, 2'b00, 1'b0);
        check("t3_awaddr", rec_awaddr, 32'h0000_0088);
        check("t3_aw_cycles", aw_hi, 4);
        check("t3_w_cycles", w_hi, 1);
        check("t3_latency", lat, 6);

        // SLVERR read with err_clear held high: the set must win.
        err_clear = 1'b1;
        do_read(32'h7, 32'h1111_2222, 0, 0, 2'b10);
        check("t4_err_set", err_sticky, 1'b1);
        do_write(32'h8, 32'h5555_AAAA, 4'h3, 0, 0, 0, 2'b00, 1'b0);
        check("t4_err_kept", err_sticky, 1'b1);
        err_clear = 1'b1;
        @(posedge ACLK); #1;
        err_clear = 1'b0;
        check("t4_err_cleared", err_sticky, 1'b0);

        // Read and write together: write wins; DECERR on B sets the flag.
        do_write(32'h1F, 32'hCAFE_0001, 4'hC, 0, 0, 0, 2'b11, 1'b1);
        check("t5_awaddr", rec_awaddr, 32'h0000_007C);
        check("t5_ar_cycles", ar_hi, 0);
        check("t5_err", err_sticky, 1'b1);
        err_clear = 1'b1;
        @(posedge ACLK); #1;
        err_clear = 1'b0;

        // Reset while waiting for BVALID.
        M_AXI_AWREADY = 1'b1; M_AXI_WREADY = 1'b1;
        issue(1'b1, 1'b0, 32'h20, 32'h7777_8888, 4'hF, 32'h0, 1'b0);
        begin
            bit ok = 0;
            for (int c = 0; c < TMO; c++) begin
                @(posedge ACLK); #1;
                if (M_AXI_BREADY) begin ok = 1; break; end
            end
            if (!ok) check("t6_bready_timeout", 0, 1);
        end
        M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0;
        avs_write = 1'b0; txn_active = 0;
        ARESETN = 1'b0;
        @(posedge ACLK); #1;
        check("t6_valids_low", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 5'b0);
        check("t6_wait_high", avs_waitrequest, 1'b1);
        ARESETN = 1'b1;
        do_read(32'h5, 32'h1234_5678, 0, 0, 2'b00);
        check("t6_read_latency", lat, 3);
        check("t6_readdata", rec_rdata, 32'h1234_5678);

        repeat (2) @(posedge ACLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
